// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode encodings, execute/branch command codes and
// the control bundle produced by control_unit and carried down the pipeline.
// No ports; imported by the pipeline modules.
package cpu_pkg;

    // Opcode encodings. Opcode 0 is the bubble/NOP encoding.
    localparam logic [5:0] OP_NOP  = 6'd0;
    localparam logic [5:0] OP_ADDU = 6'd1;
    localparam logic [5:0] OP_SUBU = 6'd2;
    localparam logic [5:0] OP_AND  = 6'd3;
    localparam logic [5:0] OP_OR   = 6'd4;
    localparam logic [5:0] OP_NOR  = 6'd5;
    localparam logic [5:0] OP_XOR  = 6'd6;
    localparam logic [5:0] OP_SLA  = 6'd7;
    localparam logic [5:0] OP_SLL  = 6'd8;
    localparam logic [5:0] OP_SRA  = 6'd9;
    localparam logic [5:0] OP_SRL  = 6'd10;
    localparam logic [5:0] OP_DIV  = 6'd11;
    localparam logic [5:0] OP_ADDI = 6'd32;
    localparam logic [5:0] OP_SUBI = 6'd33;
    localparam logic [5:0] OP_LD   = 6'd36;
    localparam logic [5:0] OP_ST   = 6'd37;
    localparam logic [5:0] OP_BEZ  = 6'd40;
    localparam logic [5:0] OP_BNE  = 6'd41;
    localparam logic [5:0] OP_BEQ  = 6'd42;
    localparam logic [5:0] OP_JMP  = 6'd43;
    localparam logic [5:0] OP_LL   = 6'd44;
    localparam logic [5:0] OP_SC   = 6'd45;

    localparam logic [3:0] EXE_DIV = 4'b0011;
    localparam logic [1:0] BR_BEQ  = 2'b11;

    // 11-bit control bundle from control_unit. The separate branch strobe is
    // carried alongside it by the stages that need it.
    typedef struct packed {
        logic       imm_check;
        logic       store_check;
        logic       wb;
        logic       mem_read;
        logic       mem_write;
        logic [3:0] exe_cmd;
        logic [1:0] br_cmd;
    } ctrl_t;

    function automatic logic is_div(input logic [3:0] exe_cmd);
        return exe_cmd == EXE_DIV;
    endfunction

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard detector.
// Ports:
//   ex_mem_read, ex_dest : load currently in EX and its destination register
//   id_rs, id_rt         : source indices of the instruction in ID
//   id_imm_check, id_mem_write, id_br_cmd : decide whether ID reads rt
//   div_busy             : EX is holding a DIV; suppresses the hazard
//   hazard               : ID must wait one cycle for the load result
module load_use_detect
    import cpu_pkg::*;
#(
    parameter int unsigned REG_W = 5
) (
    input  logic             ex_mem_read,
    input  logic [REG_W-1:0] ex_dest,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_imm_check,
    input  logic             id_mem_write,
    input  logic [1:0]       id_br_cmd,
    input  logic             div_busy,
    output logic             hazard
);

    logic rt_used;

    always_comb begin
        // rt is a source for R-type, stores (data) and BEQ (compare operand).
        rt_used = ~id_imm_check | id_mem_write | (id_br_cmd == BR_BEQ);
        hazard  = ex_mem_read & (ex_dest != '0)
                & ((ex_dest == id_rs) | (rt_used & (ex_dest == id_rt)))
                & ~div_busy;
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register. Latches the control bundle and decoded operands,
// generates the load-use hazard for control_unit, holds EX for multi-cycle DIV
// and turns branch flushes into bubbles.
// Ports:
//   clk, rst     : clock and synchronous active-high reset
//   flush        : branch taken in EX; replace the ID instruction by a bubble
//   id_*         : control bundle, operands and register indices from decode
//   hazard       : combinational load-use detect (to control_unit)
//   stall        : freeze PC and IF/ID (hazard or DIV in progress)
//   div_busy     : EX is holding a DIV
//   ex_*         : registered copies of the id_* inputs, ex_dest = destination
module id_ex_stage
    import cpu_pkg::*;
#(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned REG_W      = 5,
    parameter int unsigned DIV_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              id_branch,
    input  logic              id_imm_check,
    input  logic              id_store_check,
    input  logic              id_wb,
    input  logic              id_mem_read,
    input  logic              id_mem_write,
    input  logic [3:0]        id_exe_cmd,
    input  logic [1:0]        id_br_cmd,
    input  logic [DATA_W-1:0] id_pc,
    input  logic [DATA_W-1:0] id_rs_val,
    input  logic [DATA_W-1:0] id_rt_val,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [REG_W-1:0]  id_rs,
    input  logic [REG_W-1:0]  id_rt,
    input  logic [REG_W-1:0]  id_rd,
    output logic              hazard,
    output logic              stall,
    output logic              div_busy,
    output logic              ex_branch,
    output logic              ex_imm_check,
    output logic              ex_store_check,
    output logic              ex_wb,
    output logic              ex_mem_read,
    output logic              ex_mem_write,
    output logic [3:0]        ex_exe_cmd,
    output logic [1:0]        ex_br_cmd,
    output logic [DATA_W-1:0] ex_pc,
    output logic [DATA_W-1:0] ex_rs_val,
    output logic [DATA_W-1:0] ex_rt_val,
    output logic [DATA_W-1:0] ex_imm,
    output logic [REG_W-1:0]  ex_rs,
    output logic [REG_W-1:0]  ex_rt,
    output logic [REG_W-1:0]  ex_rd,
    output logic [REG_W-1:0]  ex_dest
);

    localparam int unsigned CntW = $clog2(DIV_CYCLES) + 1;

    typedef struct packed {
        logic              branch;
        ctrl_t             ctrl;
        logic [DATA_W-1:0] pc;
        logic [DATA_W-1:0] rs_val;
        logic [DATA_W-1:0] rt_val;
        logic [DATA_W-1:0] imm;
        logic [REG_W-1:0]  rs;
        logic [REG_W-1:0]  rt;
        logic [REG_W-1:0]  rd;
        logic [REG_W-1:0]  dest;
    } bundle_t;

    bundle_t         id_bundle;
    bundle_t         ex_q, ex_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        id_bundle                  = '0;
        id_bundle.branch           = id_branch;
        id_bundle.ctrl.imm_check   = id_imm_check;
        id_bundle.ctrl.store_check = id_store_check;
        id_bundle.ctrl.wb          = id_wb;
        id_bundle.ctrl.mem_read    = id_mem_read;
        id_bundle.ctrl.mem_write   = id_mem_write;
        id_bundle.ctrl.exe_cmd     = id_exe_cmd;
        id_bundle.ctrl.br_cmd      = id_br_cmd;
        id_bundle.pc               = id_pc;
        id_bundle.rs_val           = id_rs_val;
        id_bundle.rt_val           = id_rt_val;
        id_bundle.imm              = id_imm;
        id_bundle.rs               = id_rs;
        id_bundle.rt               = id_rt;
        id_bundle.rd               = id_rd;
        id_bundle.dest             = id_imm_check ? id_rt : id_rd;
    end

    assign div_busy = (cnt_q != '0);

    load_use_detect #(
        .REG_W (REG_W)
    ) u_load_use_detect (
        .ex_mem_read  (ex_q.ctrl.mem_read),
        .ex_dest      (ex_q.dest),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_imm_check (id_imm_check),
        .id_mem_write (id_mem_write),
        .id_br_cmd    (id_br_cmd),
        .div_busy     (div_busy),
        .hazard       (hazard)
    );

    assign stall = hazard | div_busy;

    // Bubbles are the all-zero bundle, which downstream decodes as a NOP.
    always_comb begin
        ex_d  = ex_q;
        cnt_d = cnt_q;
        if (flush) begin
            ex_d  = '0;
            cnt_d = '0;
        end else if (div_busy) begin
            cnt_d = cnt_q - CntW'(1);
        end else if (hazard) begin
            ex_d = '0;
        end else begin
            ex_d = id_bundle;
            if (is_div(id_exe_cmd)) begin
                cnt_d = CntW'(DIV_CYCLES - 1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q  <= '0;
            cnt_q <= '0;
        end else begin
            ex_q  <= ex_d;
            cnt_q <= cnt_d;
        end
    end

    assign ex_branch      = ex_q.branch;
    assign ex_imm_check   = ex_q.ctrl.imm_check;
    assign ex_store_check = ex_q.ctrl.store_check;
    assign ex_wb          = ex_q.ctrl.wb;
    assign ex_mem_read    = ex_q.ctrl.mem_read;
    assign ex_mem_write   = ex_q.ctrl.mem_write;
    assign ex_exe_cmd     = ex_q.ctrl.exe_cmd;
    assign ex_br_cmd      = ex_q.ctrl.br_cmd;
    assign ex_pc          = ex_q.pc;
    assign ex_rs_val      = ex_q.rs_val;
    assign ex_rt_val      = ex_q.rt_val;
    assign ex_imm         = ex_q.imm;
    assign ex_rs          = ex_q.rs;
    assign ex_rt          = ex_q.rt;
    assign ex_rd          = ex_q.rd;
    assign ex_dest        = ex_q.dest;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed, table-driven bench for id_ex_stage (DIV_CYCLES = 4).
// Each record drives ID for one cycle, checks hazard/stall/div_busy before the
// edge and the whole EX bundle after it. exp_src names the record whose ID
// contents must sit in EX after the edge (-1 = bubble).
module tb_id_ex_stage;

    localparam int unsigned DATA_W     = 32;
    localparam int unsigned REG_W      = 5;
    localparam int unsigned DIV_CYCLES = 4;
    localparam logic [31:0] KRS        = 32'hA5A5_0000;
    localparam logic [31:0] KRT        = 32'h0000_5A5A;

    logic        clk = 1'b0;
    logic        rst, flush;
    logic        id_branch, id_imm_check, id_store_check, id_wb, id_mem_read, id_mem_write;
    logic [3:0]  id_exe_cmd;
    logic [1:0]  id_br_cmd;
    logic [31:0] id_pc, id_rs_val, id_rt_val, id_imm;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic        hazard, stall, div_busy;
    logic        ex_branch, ex_imm_check, ex_store_check, ex_wb, ex_mem_read, ex_mem_write;
    logic [3:0]  ex_exe_cmd;
    logic [1:0]  ex_br_cmd;
    logic [31:0] ex_pc, ex_rs_val, ex_rt_val, ex_imm;
    logic [4:0]  ex_rs, ex_rt, ex_rd, ex_dest;

    always #5 clk = ~clk;

    id_ex_stage #(
        .DATA_W     (DATA_W),
        .REG_W      (REG_W),
        .DIV_CYCLES (DIV_CYCLES)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .flush          (flush),
        .id_branch      (id_branch),
        .id_imm_check   (id_imm_check),
        .id_store_check (id_store_check),
        .id_wb          (id_wb),
        .id_mem_read    (id_mem_read),
        .id_mem_write   (id_mem_write),
        .id_exe_cmd     (id_exe_cmd),
        .id_br_cmd      (id_br_cmd),
        .id_pc          (id_pc),
        .id_rs_val      (id_rs_val),
        .id_rt_val      (id_rt_val),
        .id_imm         (id_imm),
        .id_rs          (id_rs),
        .id_rt          (id_rt),
        .id_rd          (id_rd),
        .hazard         (hazard),
        .stall          (stall),
        .div_busy       (div_busy),
        .ex_branch      (ex_branch),
        .ex_imm_check   (ex_imm_check),
        .ex_store_check (ex_store_check),
        .ex_wb          (ex_wb),
        .ex_mem_read    (ex_mem_read),
        .ex_mem_write   (ex_mem_write),
        .ex_exe_cmd     (ex_exe_cmd),
        .ex_br_cmd      (ex_br_cmd),
        .ex_pc          (ex_pc),
        .ex_rs_val      (ex_rs_val),
        .ex_rt_val      (ex_rt_val),
        .ex_imm         (ex_imm),
        .ex_rs          (ex_rs),
        .ex_rt          (ex_rt),
        .ex_rd          (ex_rd),
        .ex_dest        (ex_dest)
    );

    typedef enum int {B_ADDI, B_ADDU, B_LL, B_BEQ, B_SW, B_DIV} bop_t;

    typedef struct {
        string       name;
        logic        rst;
        logic        flush;
        logic        branch, imm_check, store_check, wb, mem_read, mem_write;
        logic [3:0]  exe_cmd;
        logic [1:0]  br_cmd;
        logic [4:0]  rs, rt, rd;
        logic [31:0] imm, pc;
        logic        exp_hazard, exp_stall;
        int          exp_src;
    } vec_t;

    vec_t vecs[40];
    int   nvec = 0;
    int   applied = 0;
    int   miscompares = 0;

    task automatic add(input string name, input logic r, input logic f, input bop_t op,
                       input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                       input logic [31:0] imm, input logic [31:0] pc,
                       input logic eh, input logic es, input int src);
        vec_t v;
        v.name = name; v.rst = r; v.flush = f;
        v.branch = 0; v.imm_check = 0; v.store_check = 0; v.wb = 0;
        v.mem_read = 0; v.mem_write = 0; v.exe_cmd = 4'b0001; v.br_cmd = 2'b00;
        case (op)
            B_ADDI: begin v.wb = 1; v.imm_check = 1; end
            B_ADDU: begin v.wb = 1; end
            B_LL:   begin v.wb = 1; v.imm_check = 1; v.mem_read = 1; end
            B_BEQ:  begin v.branch = 1; v.imm_check = 1; v.br_cmd = 2'b11; v.exe_cmd = 4'b0000; end
            B_SW:   begin v.imm_check = 1; v.mem_write = 1; v.store_check = 1; end
            B_DIV:  begin v.wb = 1; v.exe_cmd = 4'b0011; end
            default: ;
        endcase
        v.rs = rs; v.rt = rt; v.rd = rd; v.imm = imm; v.pc = pc;
        v.exp_hazard = eh; v.exp_stall = es; v.exp_src = src;
        vecs[nvec] = v;
        nvec++;
    endtask

    task automatic drive(input vec_t v);
        rst = v.rst; flush = v.flush;
        id_branch = v.branch; id_imm_check = v.imm_check; id_store_check = v.store_check;
        id_wb = v.wb; id_mem_read = v.mem_read; id_mem_write = v.mem_write;
        id_exe_cmd = v.exe_cmd; id_br_cmd = v.br_cmd;
        id_pc = v.pc; id_rs_val = v.pc ^ KRS; id_rt_val = v.pc ^ KRT; id_imm = v.imm;
        id_rs = v.rs; id_rt = v.rt; id_rd = v.rd;
    endtask

    function automatic logic [159:0] exp_bundle(input int src);
        vec_t v;
        if (src < 0) return '0;
        v = vecs[src];
        return {v.branch, v.imm_check, v.store_check, v.wb, v.mem_read, v.mem_write,
                v.exe_cmd, v.br_cmd, v.pc, v.pc ^ KRS, v.pc ^ KRT, v.imm,
                v.rs, v.rt, v.rd, (v.imm_check ? v.rt : v.rd)};
    endfunction

    function automatic logic [159:0] act_bundle();
        return {ex_branch, ex_imm_check, ex_store_check, ex_wb, ex_mem_read, ex_mem_write,
                ex_exe_cmd, ex_br_cmd, ex_pc, ex_rs_val, ex_rt_val, ex_imm,
                ex_rs, ex_rt, ex_rd, ex_dest};
    endfunction

    task automatic chk(input string name, input string what,
                       input logic [159:0] act, input logic [159:0] exp);
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s/%s: got %h, expected %h", name, what, act, exp);
        end
    endtask

    initial begin
        // rst, flush, op, rs, rt, rd, imm, pc, exp_hazard, exp_stall, exp_src
        add("reset",       1, 0, B_ADDI, 5'd1, 5'd7,  5'd3,  32'h0000_1234, 32'h0000_00F0, 0, 0, -1);
        add("addi_pass",   0, 0, B_ADDI, 5'd1, 5'd7,  5'd0,  32'hFFFF_FFFC, 32'h0000_0100, 0, 0, 1);
        add("ll_rt5",      0, 0, B_LL,   5'd2, 5'd5,  5'd0,  32'h0000_0008, 32'h0000_0104, 0, 0, 2);
        add("addu_use5",   0, 0, B_ADDU, 5'd5, 5'd6,  5'd10, 32'h0000_0000, 32'h0000_0108, 1, 1, -1);
        add("addu_retry",  0, 0, B_ADDU, 5'd5, 5'd6,  5'd10, 32'h0000_0000, 32'h0000_0108, 0, 0, 4);
        add("ll_rt0",      0, 0, B_LL,   5'd3, 5'd0,  5'd0,  32'h0000_0004, 32'h0000_010C, 0, 0, 5);
        add("addu_use0",   0, 0, B_ADDU, 5'd0, 5'd0,  5'd11, 32'h0000_0000, 32'h0000_0110, 0, 0, 6);
        add("ll_rt9",      0, 0, B_LL,   5'd1, 5'd9,  5'd0,  32'h0000_0000, 32'h0000_0114, 0, 0, 7);
        add("beq_rt9",     0, 0, B_BEQ,  5'd4, 5'd9,  5'd0,  32'h0000_0010, 32'h0000_0118, 1, 1, -1);
        add("beq_retry",   0, 0, B_BEQ,  5'd4, 5'd9,  5'd0,  32'h0000_0010, 32'h0000_0118, 0, 0, 9);
        add("ll_rt9_b",    0, 0, B_LL,   5'd1, 5'd9,  5'd0,  32'h0000_0000, 32'h0000_011C, 0, 0, 10);
        add("addi_dst9",   0, 0, B_ADDI, 5'd4, 5'd9,  5'd0,  32'h0000_0001, 32'h0000_0120, 0, 0, 11);
        add("ll_rt12",     0, 0, B_LL,   5'd1, 5'd12, 5'd0,  32'h0000_0000, 32'h0000_0124, 0, 0, 12);
        add("sw_rt12",     0, 0, B_SW,   5'd2, 5'd12, 5'd0,  32'h0000_0000, 32'h0000_0128, 1, 1, -1);
        add("sw_retry",    0, 0, B_SW,   5'd2, 5'd12, 5'd0,  32'h0000_0000, 32'h0000_0128, 0, 0, 14);
        add("div_load",    0, 0, B_DIV,  5'd1, 5'd2,  5'd3,  32'h0000_0000, 32'h0000_0130, 0, 0, 15);
        add("div_busy1",   0, 0, B_ADDU, 5'd3, 5'd4,  5'd5,  32'h0000_0000, 32'h0000_0134, 0, 1, 15);
        add("div_busy2",   0, 0, B_ADDU, 5'd3, 5'd4,  5'd5,  32'h0000_0000, 32'h0000_0134, 0, 1, 15);
        add("div_busy3",   0, 0, B_ADDU, 5'd3, 5'd4,  5'd5,  32'h0000_0000, 32'h0000_0134, 0, 1, 15);
        add("div_release", 0, 0, B_ADDU, 5'd3, 5'd4,  5'd5,  32'h0000_0000, 32'h0000_0134, 0, 0, 19);
        add("div2_load",   0, 0, B_DIV,  5'd1, 5'd2,  5'd3,  32'h0000_0000, 32'h0000_0138, 0, 0, 20);
        add("div2_busy1",  0, 0, B_ADDU, 5'd6, 5'd7,  5'd8,  32'h0000_0000, 32'h0000_013C, 0, 1, 20);
        add("div2_flush",  0, 1, B_ADDU, 5'd6, 5'd7,  5'd8,  32'h0000_0000, 32'h0000_0140, 0, 1, -1);
        add("post_flush",  0, 0, B_ADDU, 5'd6, 5'd7,  5'd8,  32'h0000_0000, 32'h0000_0144, 0, 0, 23);
        add("ll_rt5_c",    0, 0, B_LL,   5'd1, 5'd5,  5'd0,  32'h0000_0000, 32'h0000_0148, 0, 0, 24);
        add("flush_haz",   0, 1, B_ADDU, 5'd5, 5'd6,  5'd10, 32'h0000_0000, 32'h0000_014C, 1, 1, -1);
        add("haz_recalc",  0, 0, B_ADDU, 5'd5, 5'd6,  5'd10, 32'h0000_0000, 32'h0000_0150, 0, 0, 26);
        add("div3_load",   0, 0, B_DIV,  5'd1, 5'd2,  5'd3,  32'h0000_0000, 32'h0000_0154, 0, 0, 27);
        add("div3_busy1",  0, 0, B_ADDU, 5'd1, 5'd2,  5'd4,  32'h0000_0000, 32'h0000_0158, 0, 1, 27);
        add("div3_rst",    1, 0, B_ADDU, 5'd1, 5'd2,  5'd4,  32'h0000_0000, 32'h0000_015C, 0, 1, -1);
        add("post_rst",    0, 0, B_ADDU, 5'd1, 5'd2,  5'd4,  32'h0000_0000, 32'h0000_0160, 0, 0, 30);
        add("tail",        0, 0, B_ADDI, 5'd2, 5'd3,  5'd0,  32'h0000_0005, 32'h0000_0164, 0, 0, 31);

        // First reset cycle with live ID inputs; registers are unknown before it.
        drive(vecs[0]);
        @(posedge clk);

        for (int i = 0; i < nvec; i++) begin
            @(negedge clk);
            drive(vecs[i]);
            #1;
            chk(vecs[i].name, "hazard",   160'(hazard),   160'(vecs[i].exp_hazard));
            chk(vecs[i].name, "stall",    160'(stall),    160'(vecs[i].exp_stall));
            chk(vecs[i].name, "div_busy", 160'(div_busy),
                160'(vecs[i].exp_stall & ~vecs[i].exp_hazard));
            @(posedge clk);
            #1;
            chk(vecs[i].name, "ex_bundle", act_bundle(), exp_bundle(vecs[i].exp_src));
            applied++;
        end

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule
